// File: rtl/systolic_feeder_if.sv
// systolic_feeder bus: operand write port, start request and PE array edge drive.
interface systolic_feeder_if #(
   parameter int ROWS = 4,
   parameter int COLS = 4,
   parameter int K    = 4,
   parameter int AW   = $clog2((ROWS*K > K*COLS) ? ROWS*K : K*COLS)
);
   logic                 wr_en;
   logic                 wr_sel;
   logic [AW-1:0]        wr_addr;
   logic [7:0]           wr_data;
   logic                 start;
   logic [ROWS-1:0][7:0] arr_a;
   logic [COLS-1:0][7:0] arr_w;
   logic                 arr_fire;
   logic                 busy;
   logic                 done;

   modport master (
      output wr_en, wr_sel, wr_addr, wr_data, start,
      input  arr_a, arr_w, arr_fire, busy, done
   );

   modport slave (
      input  wr_en, wr_sel, wr_addr, wr_data, start,
      output arr_a, arr_w, arr_fire, busy, done
   );
endinterface

// File: rtl/systolic_feeder.sv
// Holds one A and one W tile and streams them, diagonally skewed, into the PE array edges.
module systolic_feeder #(
   parameter int ROWS = 4,
   parameter int COLS = 4,
   parameter int K    = 4,
   parameter int AW   = $clog2((ROWS*K > K*COLS) ? ROWS*K : K*COLS)
) (
   input  logic             clk,
   input  logic             rstn,
   systolic_feeder_if.slave bus
);
   localparam int NA  = ROWS * K;
   localparam int NW  = K * COLS;
   localparam int AAW = (NA > 1) ? $clog2(NA) : 1;
   localparam int WAW = (NW > 1) ? $clog2(NW) : 1;
   localparam int MX  = (ROWS > COLS) ? ROWS : COLS;
   localparam int L   = K + MX - 1;
   localparam int D   = ROWS + COLS - 1;
   localparam int TM  = (L > D) ? L : D;
   localparam int CW  = $clog2(TM + 1);

   typedef enum logic [1:0] {
      S_IDLE, S_STREAM, S_DRAIN, S_DONE
   } state_e;

   state_e               state_q, state_d;
   logic [CW-1:0]        t_q, t_d;
   logic [7:0]           a_mem [NA];
   logic [7:0]           w_mem [NW];
   logic [ROWS-1:0][7:0] arr_a_q, arr_a_d;
   logic [COLS-1:0][7:0] arr_w_q, arr_w_d;
   logic                 fire_q, fire_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 wr_ok;
   int                   tc;

   assign tc = int'(t_q);

   // Writes only land in IDLE, so storage is stable for the whole run.
   assign wr_ok = rstn && bus.wr_en && (state_q == S_IDLE) &&
                  (bus.wr_sel ? (32'(bus.wr_addr) < NW)
                              : (32'(bus.wr_addr) < NA));

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         if (bus.wr_sel) w_mem[WAW'(bus.wr_addr)] <= bus.wr_data;
         else            a_mem[AAW'(bus.wr_addr)] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         t_q     <= '0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
      end
   end

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_STREAM;
               t_d     = '0;
            end
         end
         S_STREAM: begin
            if (t_q == CW'(L - 1)) begin
               state_d = S_DRAIN;
               t_d     = '0;
            end else begin
               t_d = t_q + CW'(1);
            end
         end
         S_DRAIN: begin
            if (t_q == CW'(D - 1)) begin
               state_d = S_DONE;
               t_d     = '0;
            end else begin
               t_d = t_q + CW'(1);
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Lane r lags by r cycles, lane c by c cycles; outside the window it is 0.
   always_comb begin
      arr_a_d = '0;
      arr_w_d = '0;
      fire_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         S_STREAM: begin
            busy_d = 1'b1;
            fire_d = (tc < K);
            for (int r = 0; r < ROWS; r++) begin
               if (tc >= r && tc - r < K)
                  arr_a_d[r] = a_mem[AAW'(r*K + tc - r)];
            end
            for (int c = 0; c < COLS; c++) begin
               if (tc >= c && tc - c < K)
                  arr_w_d[c] = w_mem[WAW'((tc - c)*COLS + c)];
            end
         end
         S_DRAIN: busy_d = 1'b1;
         S_DONE:  done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         arr_a_q <= '0;
         arr_w_q <= '0;
         fire_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         arr_a_q <= arr_a_d;
         arr_w_q <= arr_w_d;
         fire_q  <= fire_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.arr_a    = arr_a_q;
   assign bus.arr_w    = arr_w_q;
   assign bus.arr_fire = fire_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: reference model builds expected frames per run,
// a negedge monitor pops and compares them; directed spot checks use literal values.
module tb_systolic_feeder;
   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int K    = 4;
   localparam int AW   = 5;
   localparam int L    = K + ((ROWS > COLS) ? ROWS : COLS) - 1;
   localparam int D    = ROWS + COLS - 1;
   localparam int NCAP = 20;

   typedef struct packed {
      logic [ROWS-1:0][7:0] a;
      logic [COLS-1:0][7:0] w;
      logic                 fire;
      logic                 busy;
      logic                 done;
   } frame_t;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   systolic_feeder_if #(.ROWS(ROWS), .COLS(COLS), .K(K), .AW(AW)) bus ();

   systolic_feeder #(.ROWS(ROWS), .COLS(COLS), .K(K), .AW(AW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int npass  = 0;
   int ntotal = 0;
   bit mon_en = 1'b0;

   logic [7:0] ma [ROWS*K];
   logic [7:0] mw [K*COLS];
   frame_t     exp_q[$];
   int         run_left = 0;

   logic [ROWS-1:0][7:0] ra [NCAP];
   logic [COLS-1:0][7:0] rw [NCAP];
   logic                 rf [NCAP];
   logic                 rb [NCAP];
   logic                 rd [NCAP];

   task automatic check(input string nm, input logic [63:0] got,
                        input logic [63:0] req);
      ntotal++;
      if (got === req) npass++;
      else $display("FAIL %s: got %h, required %h", nm, got, req);
   endtask

   // Stream cycle t: lane r shows A row r element (t-r), lane c shows W column c element (t-c).
   function automatic frame_t stream_frame(input int t);
      frame_t f;
      f      = '0;
      f.busy = 1'b1;
      f.fire = (t < K);
      for (int r = 0; r < ROWS; r++)
         if (t - r >= 0 && t - r < K) f.a[r] = ma[r*K + (t - r)];
      for (int c = 0; c < COLS; c++)
         if (t - c >= 0 && t - c < K) f.w[c] = mw[(t - c)*COLS + c];
      return f;
   endfunction

   always @(posedge clk) begin : model
      frame_t f;
      if (!rstn) begin
         exp_q.delete();
         run_left = 0;
      end else if (run_left > 0) begin
         run_left--;
      end else begin
         if (bus.wr_en) begin
            if (!bus.wr_sel && int'(bus.wr_addr) < ROWS*K)
               ma[int'(bus.wr_addr)] = bus.wr_data;
            else if (bus.wr_sel && int'(bus.wr_addr) < K*COLS)
               mw[int'(bus.wr_addr)] = bus.wr_data;
         end
         if (bus.start) begin
            f = '0;
            exp_q.push_back(f);
            for (int t = 0; t < L; t++) exp_q.push_back(stream_frame(t));
            f.busy = 1'b1;
            for (int d = 0; d < D; d++) exp_q.push_back(f);
            f = '0;
            f.done = 1'b1;
            exp_q.push_back(f);
            run_left = L + D + 1;
         end
      end
   end

   always @(negedge clk) begin : monitor
      frame_t e, g;
      if (mon_en) begin
         e = '0;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         g.a    = bus.arr_a;
         g.w    = bus.arr_w;
         g.fire = bus.arr_fire;
         g.busy = bus.busy;
         g.done = bus.done;
         ntotal++;
         if (g === e) npass++;
         else $display("FAIL frame @%0t: got a=%h w=%h f=%b b=%b d=%b, required a=%h w=%h f=%b b=%b d=%b",
                       $time, g.a, g.w, g.fire, g.busy, g.done, e.a, e.w, e.fire, e.busy, e.done);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic sel, input int addr, input logic [7:0] data);
      bus.wr_en   = 1'b1;
      bus.wr_sel  = sel;
      bus.wr_addr = AW'(addr);
      bus.wr_data = data;
      tick();
      bus.wr_en = 1'b0;
   endtask

   // Pulses start, then records the NCAP cycles after the start edge (index 1+t = stream cycle t).
   task automatic capture(input int rs_at, input int wr_at);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < NCAP; i++) begin
         @(negedge clk);
         ra[i] = bus.arr_a;
         rw[i] = bus.arr_w;
         rf[i] = bus.arr_fire;
         rb[i] = bus.busy;
         rd[i] = bus.done;
         bus.start   = (i == rs_at);
         bus.wr_en   = (i == wr_at);
         bus.wr_sel  = 1'b0;
         bus.wr_addr = '0;
         bus.wr_data = 8'hFF;
      end
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
   endtask

   task automatic skew_checks(input string tag);
      check({tag, "_a_t0"}, 64'(ra[1]), 64'h0000_0001);
      check({tag, "_w_t0"}, 64'(rw[1]), 64'h0000_0040);
      check({tag, "_a_t3"}, 64'(ra[4]), 64'h0D0A_0704);
      check({tag, "_w_t3"}, 64'(rw[4]), 64'h4346_494C);
      check({tag, "_a_t6"}, 64'(ra[7]), 64'h1000_0000);
      check({tag, "_w_t6"}, 64'(rw[7]), 64'h4F00_0000);
   endtask

   initial begin : stim
      logic [NCAP-1:0] bm, fm, dm;
      logic [63:0]     drain_or;
      int              dcnt, found;

      rstn        = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_sel  = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.start   = 1'b0;
      tick();
      mon_en = 1'b1;
      tick();
      rstn = 1'b1;

      for (int i = 0; i < ROWS*K; i++) write(1'b0, i, 8'(i + 1));
      for (int i = 0; i < K*COLS; i++) write(1'b1, i, 8'(8'h40 + i));

      // Held reset with start and a write pending: both must be dropped.
      rstn        = 1'b0;
      bus.start   = 1'b1;
      bus.wr_en   = 1'b1;
      bus.wr_sel  = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = 8'hEE;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_outputs", {bus.arr_a, bus.arr_w, 29'd0, bus.arr_fire,
                               bus.busy, bus.done}, 64'd0);
      end
      tick();
      rstn      = 1'b1;
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      repeat (2) tick();

      capture(3, 10);
      skew_checks("run1");
      bm = '0; fm = '0; dm = '0; drain_or = '0;
      for (int i = 0; i < NCAP; i++) begin
         bm[i] = rb[i];
         fm[i] = rf[i];
         dm[i] = rd[i];
         if (i >= 1 + L && i < 1 + L + D) drain_or |= 64'({ra[i], rw[i]});
      end
      check("busy_window", 64'(bm), 64'h0_7FFE);
      check("fire_window", 64'(fm), 64'h0_001E);
      check("done_window", 64'(dm), 64'h0_8000);
      check("drain_zero", drain_or, 64'd0);

      write(1'b0, 16, 8'h77);
      write(1'b1, 20, 8'h77);
      tick();
      capture(-1, -1);
      check("run2_a0_kept", 64'(ra[1]), 64'h0000_0001);
      check("run2_w_t3", 64'(rw[4]), 64'h4346_494C);

      // Abort at stream cycle 4.
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 6; i++) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      check("midrst_outputs", {bus.arr_a, bus.arr_w, 29'd0, bus.arr_fire,
                               bus.busy, bus.done}, 64'd0);
      rstn = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.done) dcnt++;
      end
      check("midrst_no_done", 64'(dcnt), 64'd0);
      tick();
      capture(-1, -1);
      skew_checks("fresh");

      // Back-to-back: restart in the done cycle with a coincident write.
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      found = 0;
      for (int i = 0; i < 40 && found == 0; i++) begin
         @(negedge clk);
         if (bus.done) found = 1;
      end
      check("b2b_done_seen", 64'(found), 64'd1);
      bus.start   = 1'b1;
      bus.wr_en   = 1'b1;
      bus.wr_sel  = 1'b0;
      bus.wr_addr = AW'(5);
      bus.wr_data = 8'h99;
      tick();
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("b2b_busy_t0", 64'(bus.busy), 64'd1);
      @(negedge clk);
      @(negedge clk);
      check("b2b_a1_t2", 64'(bus.arr_a[1]), 64'h99);
      check("b2b_a0_t2", 64'(bus.arr_a[0]), 64'h03);
      repeat (20) tick();

      for (int n = 0; n < 600; n++) begin
         bus.wr_en   = ($urandom_range(0, 2) == 0);
         bus.wr_sel  = 1'($urandom_range(0, 1));
         bus.wr_addr = AW'($urandom_range(0, 31));
         bus.wr_data = 8'($urandom);
         bus.start   = ($urandom_range(0, 15) == 0);
         rstn        = ($urandom_range(0, 150) != 0);
         tick();
      end
      rstn      = 1'b1;
      bus.wr_en = 1'b0;
      bus.start = 1'b0;
      repeat (40) tick();

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end
endmodule
